bus_arbiter_4: RTL and testbench
================================

Name: bus_arbiter_4

Overview:
- Round-robin arbiter and sequencer that shares one 32-bit downstream bus among four requesters.
- Selects a winner, drives the select of an internal mux_4 (requester data in0..in3 → out) and holds the grant for a multi-beat burst until the requester flags its last beat.
- A watchdog forcibly releases a grant held by a requester that stalls.
- Sits between producer units (e.g. regfile/memory/writeback sources) and a single shared 32-bit consumer.

Parameters:
- TIMEOUT, 16: consecutive granted cycles with the granted req low before forced release. Range 2..255. The counter is 8 bits.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req  input  4  req[i]: requester i has a valid beat on in<i>
- last  input  4  last[i]: the current beat from requester i ends its burst. Only meaningful with req[i].
- in0, in1, in2, in3  input  32 each  requester data
- out_ready  input  1  downstream accepts a beat this cycle
- out  output  32  mux_4(select, in0..in3), combinational
- out_valid  output  1  beat on out is valid
- accept  output  4  one-hot: beat from requester i consumed this cycle
- grant  output  4  one-hot owner of the bus, or 0 when idle
- select  output  2  registered mux select (current or most recent owner)
- busy  output  1  state == GRANT
- timeout  output  1  one-cycle pulse after a forced release

Behaviour:
- Interface: one clock (clock). Reset is synchronous and active-high: it acts only on a rising edge of clock while high.

Registered state:
- state: IDLE or GRANT
- select[1:0]
- ptr[1:0]: last released owner
- cnt[7:0]
- timeout

Reset values:
- state = IDLE, select = 0, ptr = 3 (requester 0 has first priority), cnt = 0, timeout = 0.
- Resulting outputs: grant = 0, accept = 0, out_valid = 0, busy = 0, out = in0.

Combinational outputs:
- grant = (state == GRANT) ? onehot(select) : 0
- out_valid = busy & req[select]
- accept = grant & {4{out_valid & out_ready}}
- A transfer occurs in a cycle with out_valid & out_ready.

IDLE:
- If req == 0, stay in IDLE. select holds its value.
- Otherwise the winner is the first i with req[i] set, scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
- Next edge: select = winner, state = GRANT, cnt = 0.
- Arbitration latency is one cycle: req is sampled in IDLE and grant appears the following cycle. No beat transfers in IDLE.

GRANT:
- The owner is fixed. Other requesters are ignored and their accept stays 0 (no pre-emption).
- Transfer with last[select] = 1: next state = IDLE, ptr = select, cnt = 0.
- Transfer with last[select] = 0: stay in GRANT, cnt = 0.
- req[select] = 1 with out_ready = 0: stay in GRANT, cnt = 0 (downstream backpressure never counts toward timeout).
- req[select] = 0:
  - If cnt == TIMEOUT-1: forced release. Next state = IDLE, ptr = select, cnt = 0, timeout = 1 for the following cycle.
  - Otherwise cnt = cnt + 1.
- A release always costs one IDLE cycle before the next grant. Maximum throughput is therefore N beats per N+1 cycles per burst.

timeout register:
- Set only on a forced release. Cleared on every other edge, so it is a single-cycle pulse.

Boundary and priority rules:
- A single-beat burst (last set on the first beat) is legal: GRANT for exactly one cycle when out_ready = 1.
- If a transfer and a timeout are both possible, the transfer wins (cnt only advances when req is low).
- last without req is ignored.
- A requester whose req drops mid-burst keeps the grant until it returns or the timeout fires.
- Fairness: a requester that has just released gets the lowest priority in the next arbitration.
- Reset mid-burst: the next edge returns to the reset values above. The in-flight burst is abandoned with no accept, and timeout does not pulse.
- select and out remain stable through IDLE (they show the last owner). Downstream must qualify out with out_valid.

Test Plan:
- Reset, then req = 4'b0001, last = 4'b0001, out_ready = 1, in0 = 32'hDEAD0000 → grant = 0001 one cycle after req, out = 32'hDEAD0000, out_valid = 1, accept = 0001 for one cycle, then IDLE with ptr = 0.
- req = 4'b1111 held, every beat last, out_ready = 1 → grants rotate 0, 1, 2, 3, 0, each grant separated by one IDLE cycle, with out tracking the matching in<i>.
- Burst of 3 beats from requester 2 (in2 = 1, 2, 3; last on the third beat) while req[0] and req[1] are also high → out = 1, 2, 3 on consecutive transfers with no interleaving, then requester 3 is checked before requester 0 (req[3] = 0, so requester 0 wins).
- Backpressure: requester 1 granted, out_ready = 0 for 40 cycles → no accept, no timeout, cnt stays 0; out_ready = 1 → beat transfers.
- Stall: requester 1 granted, req[1] drops, req[2] = 1 → release after exactly TIMEOUT = 16 low cycles, timeout pulses one cycle, requester 2 granted on the cycle after that pulse.
- Assert reset during GRANT mid-burst (requester 3) → next cycle grant = 0, select = 0, busy = 0; with req = 1111 the first new grant goes to requester 0.

Source files
------------

// File: rtl/bus_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter_4 (with helper mux_4)
//  Purpose  : Round-robin arbiter/sequencer sharing one 32-bit downstream bus
//             among four requesters. A grant is held for a whole multi-beat
//             burst (until the owner flags its last beat) and a watchdog
//             forcibly releases an owner that stalls for TIMEOUT cycles.
//  Ports    : clock, reset      - clock (rising edge), synchronous active-high
//             req[3:0]          - requester i has a valid beat on in<i>
//             last[3:0]         - beat from requester i ends its burst
//             in0..in3[31:0]    - requester data
//             out_ready         - downstream accepts a beat this cycle
//             out[31:0]         - data of the selected requester
//             out_valid         - beat on out is valid
//             accept[3:0]       - one-hot, beat from requester i consumed
//             grant[3:0]        - one-hot bus owner, 0 when idle
//             select[1:0]       - registered mux select (current/last owner)
//             busy              - a grant is active
//             timeout           - one-cycle pulse after a forced release
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  mux_4 : plain 4:1 x 32-bit data multiplexer
// ----------------------------------------------------------------------------
module mux_4 (
    input  logic [1:0]  sel,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [31:0] in3,
    output logic [31:0] y
);
    always_comb begin
        case (sel)
            2'd0:    y = in0;
            2'd1:    y = in1;
            2'd2:    y = in2;
            default: y = in3;
        endcase
    end
endmodule

module bus_arbiter_4 #(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [3:0]  last,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [31:0] in3,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        out_valid,
    output logic [3:0]  accept,
    output logic [3:0]  grant,
    output logic [1:0]  select,
    output logic        busy,
    output logic        timeout
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    localparam logic [7:0] C_CNT_MAX = 8'(TIMEOUT - 1);

    logic [0:0] r_state;
    logic [1:0] r_select;
    logic [1:0] r_ptr;
    logic [7:0] r_cnt;
    logic       r_timeout;

    logic       w_xfer;
    logic [1:0] w_winner;
    logic [1:0] w_c1;
    logic [1:0] w_c2;
    logic [1:0] w_c3;

    // Round-robin scan starts just after the last released owner, so the
    // requester that has just finished gets the lowest priority.
    assign w_c1 = r_ptr + 2'd1;
    assign w_c2 = r_ptr + 2'd2;
    assign w_c3 = r_ptr + 2'd3;

    always_comb begin
        if (req[w_c1])      w_winner = w_c1;
        else if (req[w_c2]) w_winner = w_c2;
        else if (req[w_c3]) w_winner = w_c3;
        else                w_winner = r_ptr;
    end

    assign busy      = (r_state == S_GRANT);
    assign grant     = busy ? (4'b0001 << r_select) : 4'b0000;
    assign out_valid = busy & req[r_select];
    assign w_xfer    = out_valid & out_ready;
    assign accept    = grant & {4{w_xfer}};
    assign select    = r_select;
    assign timeout   = r_timeout;

    mux_4 u_mux (
        .sel (r_select),
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .y   (out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_select  <= 2'd0;
            r_ptr     <= 2'd3;
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_select <= w_winner;
                        r_state  <= S_GRANT;
                        r_cnt    <= 8'd0;
                    end
                end
                default: begin
                    // A transfer always takes precedence over the watchdog;
                    // the counter only advances while the owner's req is low,
                    // so downstream backpressure never counts as a stall.
                    if (w_xfer) begin
                        r_cnt <= 8'd0;
                        if (last[r_select]) begin
                            r_state <= S_IDLE;
                            r_ptr   <= r_select;
                        end
                    end else if (req[r_select]) begin
                        r_cnt <= 8'd0;
                    end else if (r_cnt == C_CNT_MAX) begin
                        r_state   <= S_IDLE;
                        r_ptr     <= r_select;
                        r_cnt     <= 8'd0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_arbiter_4
//  Purpose  : Directed self-checking bench for bus_arbiter_4.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bus_arbiter_4;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] in0, in1, in2, in3;
    logic        out_ready;
    logic [31:0] out;
    logic        out_valid;
    logic [3:0]  accept;
    logic [3:0]  grant;
    logic [1:0]  select;
    logic        busy;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    bus_arbiter_4 #(.TIMEOUT(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .last      (last),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .out_ready (out_ready),
        .out       (out),
        .out_valid (out_valid),
        .accept    (accept),
        .grant     (grant),
        .select    (select),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance past one rising edge; inputs change and outputs are sampled
    // well away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        req = 4'b0000; last = 4'b0000; out_ready = 1'b0;
        in0 = 32'hDEAD0000; in1 = 32'h11111111; in2 = 32'h22222222; in3 = 32'h33333333;
        do_reset();
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (accept !== 4'b0000) begin failures++; $display("FAIL reset_accept: got %b want 0000", accept); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (select !== 2'd0) begin failures++; $display("FAIL reset_select: got %0d want 0", select); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        checks++; if (out !== 32'hDEAD0000) begin failures++; $display("FAIL reset_out: got %h want DEAD0000", out); end
    endtask

    task automatic test_single_beat();
        req = 4'b0001; last = 4'b0001; out_ready = 1'b1; in0 = 32'hDEAD0000;
        #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL single_latency: got %b want 0000", grant); end
        tick();
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL single_grant: got %b want 0001", grant); end
        checks++; if (out !== 32'hDEAD0000) begin failures++; $display("FAIL single_out: got %h want DEAD0000", out); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid: got %b want 1", out_valid); end
        checks++; if (accept !== 4'b0001) begin failures++; $display("FAIL single_accept: got %b want 0001", accept); end
        tick();
        req = 4'b0000;
        #1;
        checks++; if (busy !== 1'b0 || grant !== 4'b0000 || accept !== 4'b0000) begin
            failures++; $display("FAIL single_release: busy=%b grant=%b accept=%b want 0/0000/0000", busy, grant, accept);
        end
        checks++; if (select !== 2'd0) begin failures++; $display("FAIL single_select_hold: got %0d want 0", select); end
    endtask

    task automatic test_rotate();
        logic [31:0] din [4];
        int          who;
        logic [3:0]  exp_g;
        do_reset();
        din[0] = 32'h10000000; din[1] = 32'h10000001; din[2] = 32'h10000002; din[3] = 32'h10000003;
        in0 = din[0]; in1 = din[1]; in2 = din[2]; in3 = din[3];
        req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            who   = n % 4;
            exp_g = 4'b0001 << who;
            tick();
            checks++; if (grant !== exp_g || accept !== exp_g) begin
                failures++; $display("FAIL rotate_grant[%0d]: grant=%b accept=%b want %b", n, grant, accept, exp_g);
            end
            checks++; if (out !== din[who]) begin failures++; $display("FAIL rotate_out[%0d]: got %h want %h", n, out, din[who]); end
            tick();
            checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin
                failures++; $display("FAIL rotate_idle[%0d]: busy=%b grant=%b want 0/0000", n, busy, grant);
            end
        end
        // Last owner was requester 1.
    endtask

    task automatic test_burst();
        req = 4'b0111; last = 4'b0000; out_ready = 1'b1; in2 = 32'd1;
        tick();
        checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL burst_grant: got %b want 0100", grant); end
        for (int b = 1; b <= 3; b++) begin
            in2  = 32'(b);
            last = (b == 3) ? 4'b0100 : 4'b0000;
            #1;
            checks++; if (out !== 32'(b) || accept !== 4'b0100) begin
                failures++; $display("FAIL burst_beat[%0d]: out=%0d accept=%b want %0d/0100", b, out, accept, b);
            end
            tick();
        end
        last = 4'b0000;
        #1;
        checks++; if (busy !== 1'b0 || select !== 2'd2 || out !== 32'd3) begin
            failures++; $display("FAIL burst_idle: busy=%b select=%0d out=%0d want 0/2/3", busy, select, out);
        end
        tick();
        checks++; if (grant !== 4'b0001 || out !== in0) begin
            failures++; $display("FAIL burst_next_owner: grant=%b out=%h want 0001/%h", grant, out, in0);
        end
        last = 4'b0001;
        tick();
        req = 4'b0000; last = 4'b0000;
        #1;
    endtask

    task automatic test_backpressure();
        // ptr = 0, requester 1 is next in line.
        req = 4'b0010; last = 4'b0000; out_ready = 1'b0;
        tick();
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL bp_grant: got %b want 0010", grant); end
        for (int k = 0; k < 40; k++) begin
            tick();
            checks++; if (accept !== 4'b0000 || timeout !== 1'b0 || grant !== 4'b0010) begin
                failures++; $display("FAIL bp_hold[%0d]: accept=%b timeout=%b grant=%b want 0000/0/0010", k, accept, timeout, grant);
            end
        end
        out_ready = 1'b1; last = 4'b0010;
        #1;
        checks++; if (accept !== 4'b0010 || out_valid !== 1'b1) begin
            failures++; $display("FAIL bp_release: accept=%b out_valid=%b want 0010/1", accept, out_valid);
        end
        tick();
        req = 4'b0000; last = 4'b0000;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_stall();
        // ptr = 1; requester 1 wins when it is the only one requesting.
        req = 4'b0010; last = 4'b0000; out_ready = 1'b1;
        tick();
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL stall_grant: got %b want 0010", grant); end
        req = 4'b0100;
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++; if (grant !== 4'b0010 || timeout !== 1'b0 || accept !== 4'b0000) begin
                failures++; $display("FAIL stall_hold[%0d]: grant=%b timeout=%b accept=%b want 0010/0/0000", k, grant, timeout, accept);
            end
        end
        tick();
        checks++; if (grant !== 4'b0000 || timeout !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL stall_release: grant=%b timeout=%b busy=%b want 0000/1/0", grant, timeout, busy);
        end
        tick();
        checks++; if (grant !== 4'b0100 || timeout !== 1'b0) begin
            failures++; $display("FAIL stall_next: grant=%b timeout=%b want 0100/0", grant, timeout);
        end
        last = 4'b0100;
        tick();
        req = 4'b0000; last = 4'b0000;
        #1;
    endtask

    task automatic test_reset_mid_burst();
        // ptr = 2, requester 3 is next in line.
        req = 4'b1000; last = 4'b0000; out_ready = 1'b1;
        tick();
        checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL rstmid_grant: got %b want 1000", grant); end
        tick();
        reset = 1'b1; req = 4'b1111;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000 || select !== 2'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL rstmid_state: grant=%b select=%0d busy=%b want 0000/0/0", grant, select, busy);
        end
        checks++; if (accept !== 4'b0000 || timeout !== 1'b0) begin
            failures++; $display("FAIL rstmid_quiet: accept=%b timeout=%b want 0000/0", accept, timeout);
        end
        tick();
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL rstmid_first: got %b want 0001", grant); end
    endtask

    initial begin
        reset = 1'b0;
        test_reset();
        test_single_beat();
        test_rotate();
        test_burst();
        test_backpressure();
        test_stall();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
